dahb_master: RTL and testbench

DAHB_MASTER -- requirements
Module: dahb_master

---
 rtl/dahb_master_pkg.sv | 49 ++++
 rtl/dahb_master_if.sv | 39 +++
 rtl/dahb_cmd_fifo.sv | 50 +++++
 rtl/dahb_master.sv | 117 +++++++++++
 tb/tb_dahb_master.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dahb_master_pkg.sv
// rtl/dahb_master_pkg.sv - shared AHB encodings, FSM states and command type for dahb_master
package dahb_master_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } dahb_state_e;

  typedef struct packed {
    logic                  rd0_wr1;
    logic [3:0]            strobe;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } dahb_cmd_t;

  localparam int CMD_WIDTH = $bits(dahb_cmd_t);

  function automatic logic [2:0] strobe_size(input logic [3:0] strobe);
    case (strobe)
      4'b1111:                            return HSIZE_WORD;
      4'b0011, 4'b1100:                   return HSIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return HSIZE_BYTE;
      default:                            return HSIZE_WORD;
    endcase
  endfunction

  function automatic logic strobe_legal(input logic [3:0] strobe);
    case (strobe)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dahb_master_if.sv
// rtl/dahb_master_if.sv - DAHB request side and AHB master bus grouped with master/slave views
interface dahb_master_if;
  import dahb_master_pkg::*;

  logic                  DAHB_access;
  logic                  DAHB_rd0_wr1;
  logic [3:0]            DAHB_byte_strobe;
  logic [DATA_WIDTH-1:0] DAHB_write_data;
  logic [ADDR_WIDTH-1:0] DAHB_addr;
  logic                  DAHB_trans_buffer_full;
  logic [DATA_WIDTH-1:0] DAHB_read_data;
  logic                  DAHB_read_data_valid;
  logic                  dahb_bus_err;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    input  DAHB_access, DAHB_rd0_wr1, DAHB_byte_strobe, DAHB_write_data, DAHB_addr,
    output DAHB_trans_buffer_full, DAHB_read_data, DAHB_read_data_valid, dahb_bus_err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output DAHB_access, DAHB_rd0_wr1, DAHB_byte_strobe, DAHB_write_data, DAHB_addr,
    input  DAHB_trans_buffer_full, DAHB_read_data, DAHB_read_data_valid, dahb_bus_err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/dahb_cmd_fifo.sv
// rtl/dahb_cmd_fifo.sv - synchronous in-order command FIFO with full/empty/count
module dahb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == FULL_COUNT);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (!empty_o || do_push);

  // When empty, the incoming word is presented so it can be pushed and popped in one cycle
  assign rdata_o = empty_o ? wdata_i : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dahb_master.sv
// rtl/dahb_master.sv - buffered DAHB request port driving single AHB transfers in order
module dahb_master #(
  parameter int BUF_DEPTH = 4
) (
  input  logic          cpu_clk,
  input  logic          cpu_rstn,
  dahb_master_if.master bus
);
  import dahb_master_pkg::*;

  localparam int                    CW         = $clog2(BUF_DEPTH);
  localparam logic [CW:0]           FULL_COUNT = (CW+1)'(BUF_DEPTH);

  dahb_cmd_t             req;
  dahb_cmd_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW:0]           fifo_count;
  logic                  push;
  logic                  pop;
  logic                  cmd_avail;
  logic                  done;

  dahb_state_e           state_q;
  logic                  inflight_wr_q;
  logic                  inflight_bad_q;
  logic [DATA_WIDTH-1:0] inflight_wdata_q;
  logic [1:0]            htrans_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic                  hwrite_q;
  logic [2:0]            hsize_q;
  logic [DATA_WIDTH-1:0] hwdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  err_q;

  assign req = '{rd0_wr1: bus.DAHB_rd0_wr1, strobe: bus.DAHB_byte_strobe,
                 addr: bus.DAHB_addr, wdata: bus.DAHB_write_data};

  assign push      = bus.DAHB_access && !fifo_full;
  assign cmd_avail = !fifo_empty || push;
  assign done      = (state_q == ST_DATA) && bus.HREADY;
  assign pop       = cmd_avail && ((state_q == ST_IDLE) || done);

  dahb_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (cpu_clk),
    .rst_ni  (cpu_rstn),
    .push_i  (push),
    .wdata_i (req),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q          <= ST_IDLE;
      inflight_wr_q    <= 1'b0;
      inflight_bad_q   <= 1'b0;
      inflight_wdata_q <= '0;
      htrans_q         <= HTRANS_IDLE;
      haddr_q          <= '0;
      hwrite_q         <= 1'b0;
      hsize_q          <= HSIZE_WORD;
      hwdata_q         <= '0;
      rdata_q          <= '0;
      rvalid_q         <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (done) begin
        if (!inflight_wr_q) begin
          rvalid_q <= 1'b1;
          rdata_q  <= bus.HRESP ? '0 : bus.HRDATA;
        end
        err_q <= bus.HRESP || inflight_bad_q;
      end

      if (pop) begin
        state_q          <= ST_ADDR;
        inflight_wr_q    <= head.rd0_wr1;
        inflight_bad_q   <= !strobe_legal(head.strobe);
        inflight_wdata_q <= head.wdata;
        htrans_q         <= HTRANS_NONSEQ;
        haddr_q          <= head.addr;
        hwrite_q         <= head.rd0_wr1;
        hsize_q          <= strobe_size(head.strobe);
      end else if ((state_q == ST_ADDR) && bus.HREADY) begin
        state_q  <= ST_DATA;
        htrans_q <= HTRANS_IDLE;
        hwdata_q <= inflight_wdata_q;
      end else if (done) begin
        state_q  <= ST_IDLE;
        htrans_q <= HTRANS_IDLE;
      end
    end
  end

  assign bus.DAHB_trans_buffer_full = (fifo_count == FULL_COUNT);
  assign bus.DAHB_read_data         = rdata_q;
  assign bus.DAHB_read_data_valid   = rvalid_q;
  assign bus.dahb_bus_err           = err_q;
  assign bus.HADDR                  = haddr_q;
  assign bus.HTRANS                 = htrans_q;
  assign bus.HWRITE                 = hwrite_q;
  assign bus.HSIZE                  = hsize_q;
  assign bus.HBURST                 = HBURST_SINGLE;
  assign bus.HPROT                  = HPROT_DEFAULT;
  assign bus.HWDATA                 = hwdata_q;

endmodule

// File: tb/tb_dahb_master.sv
// tb/tb_dahb_master.sv - self-checking bench for dahb_master with transaction-level reference model
module tb_dahb_master;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dahb_master_if bus_if();

  dahb_master #(.BUF_DEPTH(DEPTH)) dut (
    .cpu_clk  (clk),
    .cpu_rstn (rst_n),
    .bus      (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted-but-not-issued requests, plus the transfer on the bus
  typedef struct {
    bit        wr;
    bit [3:0]  strb;
    bit [31:0] addr;
    bit [31:0] wdata;
  } item_t;

  item_t     q[$];
  item_t     cur;
  int        m_phase   = 0;   // 0 no transfer, 1 address phase, 2 data phase
  bit        exp_valid = 0;
  bit        exp_err   = 0;
  bit [31:0] exp_rdata = 0;
  bit        last_acc  = 0;

  function automatic int ones(input bit [3:0] s);
    return int'(s[0]) + int'(s[1]) + int'(s[2]) + int'(s[3]);
  endfunction

  function automatic bit legal(input bit [3:0] s);
    int n = ones(s);
    return (n == 4) || (n == 1) || (n == 2 && (s == 4'd3 || s == 4'd12));
  endfunction

  function automatic bit [2:0] exp_size(input bit [3:0] s);
    int n = ones(s);
    if (n == 1) return 3'd0;
    if (n == 2 && (s == 4'd3 || s == 4'd12)) return 3'd1;
    return 3'd2;
  endfunction

  always @(negedge clk) begin : model
    bit    full_exp;
    bit    done;
    item_t it;
    if (!rst_n) begin
      chk("rst_htrans", bus_if.HTRANS, 0);
      chk("rst_haddr", bus_if.HADDR, 0);
      chk("rst_hwrite", bus_if.HWRITE, 0);
      chk("rst_hsize", bus_if.HSIZE, 3'b010);
      chk("rst_hwdata", bus_if.HWDATA, 0);
      chk("rst_rdata", bus_if.DAHB_read_data, 0);
      chk("rst_valid", bus_if.DAHB_read_data_valid, 0);
      chk("rst_err", bus_if.dahb_bus_err, 0);
      chk("rst_full", bus_if.DAHB_trans_buffer_full, 0);
      q.delete();
      m_phase   = 0;
      exp_valid = 0;
      exp_err   = 0;
      exp_rdata = 0;
      last_acc  = 0;
    end else begin
      full_exp = (q.size() == DEPTH);
      chk("full", bus_if.DAHB_trans_buffer_full, full_exp);
      chk("htrans", bus_if.HTRANS, (m_phase == 1) ? 2 : 0);
      chk("hburst", bus_if.HBURST, 0);
      chk("hprot", bus_if.HPROT, 4'b0011);
      chk("rvalid", bus_if.DAHB_read_data_valid, exp_valid);
      chk("bus_err", bus_if.dahb_bus_err, exp_err);
      chk("rdata", bus_if.DAHB_read_data, exp_rdata);
      if (m_phase == 1) begin
        chk("haddr", bus_if.HADDR, cur.addr);
        chk("hwrite", bus_if.HWRITE, cur.wr);
        chk("hsize", bus_if.HSIZE, exp_size(cur.strb));
      end
      if (m_phase == 2) chk("hwdata", bus_if.HWDATA, cur.wdata);

      last_acc = bus_if.DAHB_access && !full_exp;
      if (last_acc) begin
        it.wr    = bus_if.DAHB_rd0_wr1;
        it.strb  = bus_if.DAHB_byte_strobe;
        it.addr  = bus_if.DAHB_addr;
        it.wdata = bus_if.DAHB_write_data;
        q.push_back(it);
      end
      done      = (m_phase == 2) && bus_if.HREADY;
      exp_valid = 0;
      exp_err   = 0;
      if (done) begin
        if (!cur.wr) begin
          exp_valid = 1;
          exp_rdata = bus_if.HRESP ? 32'd0 : bus_if.HRDATA;
        end
        exp_err = bus_if.HRESP || !legal(cur.strb);
      end
      if (m_phase == 1 && bus_if.HREADY) begin
        m_phase = 2;
      end else if (m_phase == 0 || done) begin
        if (q.size() > 0) begin
          cur     = q.pop_front();
          m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit acc, input bit wr, input bit [3:0] s,
                     input bit [31:0] a, input bit [31:0] d);
    bus_if.DAHB_access      = acc;
    bus_if.DAHB_rd0_wr1     = wr;
    bus_if.DAHB_byte_strobe = s;
    bus_if.DAHB_addr        = a;
    bus_if.DAHB_write_data  = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] strobes [10] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h0, 4'h7};
    int       cnt;
    int       err_stage;
    bit       pend;

    req(0, 0, 4'h0, 0, 0);
    bus_if.HRDATA = 0;
    bus_if.HREADY = 1;
    bus_if.HRESP  = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Word read, zero wait states
    bus_if.HRDATA = 32'hDEADBEEF;
    req(1, 0, 4'hF, 32'h4000_0010, 0);
    step();
    req(0, 0, 4'h0, 0, 0);
    chk("r31_htrans_p1", bus_if.HTRANS, 2'b10);
    chk("r31_hsize", bus_if.HSIZE, 3'b010);
    chk("r31_haddr", bus_if.HADDR, 32'h4000_0010);
    step();
    chk("r31_htrans_p2", bus_if.HTRANS, 2'b00);
    step();
    chk("r31_valid_p3", bus_if.DAHB_read_data_valid, 1);
    chk("r31_rdata", bus_if.DAHB_read_data, 32'hDEADBEEF);
    step();
    chk("r31_valid_once", bus_if.DAHB_read_data_valid, 0);
    chk("r31_rdata_hold", bus_if.DAHB_read_data, 32'hDEADBEEF);

    // Byte store to the top lane
    repeat (2) step();
    req(1, 1, 4'h8, 32'h2000_0003, 32'hAB00_0000);
    step();
    req(0, 0, 4'h0, 0, 0);
    chk("r33_hsize", bus_if.HSIZE, 3'b000);
    chk("r33_haddr_lo", {30'd0, bus_if.HADDR[1:0]}, 3);
    chk("r33_hwrite", bus_if.HWRITE, 1);
    step();
    chk("r33_hwdata", bus_if.HWDATA, 32'hAB00_0000);
    step();
    chk("r33_no_valid", bus_if.DAHB_read_data_valid, 0);
    chk("r33_no_err", bus_if.dahb_bus_err, 0);

    // Store then read of the same address stays ordered
    repeat (2) step();
    req(1, 1, 4'hF, 32'h3000_0100, 32'h1122_3344);
    step();
    req(1, 0, 4'hF, 32'h3000_0100, 0);
    step();
    req(0, 0, 4'h0, 0, 0);
    chk("r35_store_data", bus_if.HTRANS, 2'b00);
    chk("r35_hwdata", bus_if.HWDATA, 32'h1122_3344);
    step();
    chk("r35_read_nonseq", bus_if.HTRANS, 2'b10);
    chk("r35_read_hwrite", bus_if.HWRITE, 0);
    repeat (2) step();
    chk("r35_read_valid", bus_if.DAHB_read_data_valid, 1);

    // Read finishing with a two-cycle error response, write queued behind it
    repeat (2) step();
    bus_if.HRDATA = 32'h1234_5678;
    req(1, 0, 4'hF, 32'h5000_0000, 0);
    step();
    req(1, 1, 4'hF, 32'h5000_0040, 32'hCAFE_F00D);
    step();
    req(0, 0, 4'h0, 0, 0);
    bus_if.HREADY = 0;
    bus_if.HRESP  = 1;
    step();
    bus_if.HREADY = 1;
    step();
    bus_if.HRESP = 0;
    chk("r34_valid", bus_if.DAHB_read_data_valid, 1);
    chk("r34_rdata_zero", bus_if.DAHB_read_data, 0);
    chk("r34_err", bus_if.dahb_bus_err, 1);
    chk("r34_next_nonseq", bus_if.HTRANS, 2'b10);
    chk("r34_next_addr", bus_if.HADDR, 32'h5000_0040);
    step();
    chk("r34_err_once", bus_if.dahb_bus_err, 0);

    // Five stores with HREADY low: one in flight plus four buffered
    repeat (3) step();
    bus_if.HREADY = 0;
    for (int i = 0; i < 5; i++) begin
      req(1, 1, 4'hF, 32'h6000_0000 + 32'(4 * i), 32'h0101_0101 * 32'(i + 1));
      step();
    end
    chk("r32_full", bus_if.DAHB_trans_buffer_full, 1);
    req(1, 1, 4'hF, 32'h6000_0100, 32'hFFFF_FFFF);
    step();
    chk("r32_still_full", bus_if.DAHB_trans_buffer_full, 1);
    req(0, 0, 4'h0, 0, 0);
    bus_if.HREADY = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.HTRANS == 2'b10) cnt++;
      step();
    end
    chk("r32_issued", cnt, 5);
    chk("r32_drained", bus_if.DAHB_trans_buffer_full, 0);

    // Reset with three queued and one stalled in the data phase
    repeat (2) step();
    req(1, 1, 4'hF, 32'h7000_0000, 32'h5A5A_5A5A);
    step();
    req(1, 0, 4'hF, 32'h7000_0004, 0);
    step();
    bus_if.HREADY = 0;
    req(1, 1, 4'hF, 32'h7000_0008, 32'h0000_0008);
    step();
    req(1, 0, 4'hF, 32'h7000_000C, 0);
    step();
    req(0, 0, 4'h0, 0, 0);
    chk("r36_pre_hwdata", bus_if.HWDATA, 32'h5A5A_5A5A);
    rst_n = 1'b0;
    #1;
    chk("r36_htrans", bus_if.HTRANS, 0);
    chk("r36_hwdata", bus_if.HWDATA, 0);
    chk("r36_haddr", bus_if.HADDR, 0);
    chk("r36_full", bus_if.DAHB_trans_buffer_full, 0);
    step();
    step();
    rst_n = 1'b1;
    bus_if.HREADY = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("r36_no_valid", bus_if.DAHB_read_data_valid, 0);
      chk("r36_no_err", bus_if.dahb_bus_err, 0);
      chk("r36_idle", bus_if.HTRANS, 0);
    end

    // Randomized traffic with random wait states and error responses
    pend      = 0;
    err_stage = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (pend && last_acc) pend = 0;
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1;
        req(1, 1'($urandom_range(0, 1)), strobes[$urandom_range(0, 9)], $urandom(), $urandom());
      end
      bus_if.DAHB_access = pend;
      bus_if.HRDATA = $urandom();
      if (err_stage == 1) begin
        bus_if.HREADY = 1;
        bus_if.HRESP  = 1;
        err_stage     = 0;
      end else if (m_phase == 2 && $urandom_range(0, 5) == 0) begin
        bus_if.HREADY = 0;
        bus_if.HRESP  = 1;
        err_stage     = 1;
      end else begin
        bus_if.HRESP  = 0;
        bus_if.HREADY = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    req(0, 0, 4'h0, 0, 0);
    bus_if.HREADY = 1;
    bus_if.HRESP  = 0;
    repeat (40) step();
    chk("final_idle", bus_if.HTRANS, 0);
    chk("final_empty", bus_if.DAHB_trans_buffer_full, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
